rf_sync_deframer: RTL and testbench
===================================

# rf_sync_deframer

Recovers the bit stream from the pulse-position RF input `rfin` and frames 64-bit packets by matching a masked sync pattern. It sits directly upstream of the SPI/APB receive path: its `o_PKT` / `o_PKT_REC` outputs feed the RX data register and the packet-received flag that software polls over APB.

- One bit slot carries one bit.
  - Bit 1: a short high pulse near the nominal slot position.
  - Bit 0: no pulse in the slot.
- Pulse timing jitters by a few percent. The block tracks the jitter by re-aligning its slot timer on every accepted pulse.

## Interface
Parameters:
- `CLK_PER_BIT`, 10000: nominal slot length in `i_PCLK` cycles (1 ms at 10 MHz).
- `WIN_HALF`, 1500: half-width of the acceptance window around the expected pulse, in cycles.
- `MAX_ZEROS`, 16: consecutive 0-bits that drop lock.
- `SYNC_MASK`, 64'h7C00_001F_0000_01FF: bits of the shift register that are checked.
- `SYNC_VAL`, 64'h7C00_001F_0000_01FF: required value of the masked bits.

Ports:
- `i_PCLK`, in, 1: the block's single clock. All logic is on the rising edge.
- `i_PRESET`, in, 1: reset, asynchronous, active-high.
- `rfin`, in, 1: raw RF pulse input. Asynchronous to `i_PCLK`.
- `o_BIT_VLD`, out, 1: one-cycle strobe when a bit is decided.
- `o_BIT`, out, 1: value of the decided bit. Valid while `o_BIT_VLD` is high.
- `o_LOCK`, out, 1: slot timing is locked (state TRACK).
- `o_PKT`, out, 64: last matched packet, MSB is the first bit received. Held until the next match.
- `o_PKT_REC`, out, 1: one-cycle strobe when a packet is matched.

## Operation
- **Input conditioning**
  - `rfin` passes through a 2-flop synchronizer, then a rising-edge detector.
  - `edge` is high for 1 cycle per pulse.
  - Pulse width has no effect on the decision.
- **Slot timer**: `t`, width `$clog2(CLK_PER_BIT+WIN_HALF+1)`, unsigned. It counts cycles since the last timing reference.
- **State IDLE** (reset state, `o_LOCK`=0)
  - On `edge`: decide bit 1, set `t`=0, go to TRACK, clear the zero counter.
  - Without an edge, no bits are produced.
- **State TRACK** (`o_LOCK`=1). `t` increments every cycle.
  - `edge` with `CLK_PER_BIT-WIN_HALF <= t <= CLK_PER_BIT+WIN_HALF`:
    - decide bit 1;
    - set `t`=0 (re-align);
    - clear the zero counter.
  - `edge` with `t < CLK_PER_BIT-WIN_HALF`: ignored. No bit, `t` unchanged.
  - `t == CLK_PER_BIT+WIN_HALF` with no edge in that cycle:
    - decide bit 0;
    - set `t`=`WIN_HALF` (the nominal reference advances by exactly `CLK_PER_BIT`);
    - increment the zero counter.
  - Edge and timeout in the same cycle: the edge wins, bit 1.
  - When the zero counter reaches `MAX_ZEROS`:
    - go to IDLE;
    - clear the bit counter;
    - leave the shift register contents unchanged.
- **Framing**
  - Each decided bit shifts into `sr[63:0]` at the LSB: `sr <= {sr[62:0], bit}`.
  - `cnt` is a 7-bit bit counter that saturates at 64 and increments on each decided bit.
  - A match occurs when `cnt==64` and `(sr & SYNC_MASK) == (SYNC_VAL & SYNC_MASK)`.
  - On a match:
    - `o_PKT <= sr`;
    - `o_PKT_REC` pulses;
    - `cnt` is cleared, so the next packet needs 64 fresh bits (no overlapping matches).
  - The match is evaluated only in the cycle after a bit is shifted in.

## Timing
- All outputs reset to 0: `o_BIT_VLD`, `o_BIT`, `o_LOCK`, `o_PKT`, `o_PKT_REC`. State resets to IDLE, and `t`, `cnt`, `sr` and the zero counter reset to 0.
- `rfin` rising edge to `edge`: 2–3 cycles (synchronizer plus detector).
- `edge` in cycle E gives `o_BIT_VLD`=1 and `o_BIT`=1 in cycle E+1, with `sr` updated in E+1.
- A timeout in cycle T gives `o_BIT_VLD` in cycle T+1.
- A match gives `o_PKT_REC`=1 one cycle after the `o_BIT_VLD` of the 64th bit. `o_PKT` is valid in that same cycle and stays stable afterwards.
- `o_LOCK` rises in the cycle after the first accepted edge. It falls in the cycle after the `MAX_ZEROS`-th zero decision.
- Asserting `i_PRESET` mid-packet aborts immediately. No `o_PKT_REC` is produced for the partial frame.

## Test plan
Benches use `CLK_PER_BIT`=100, `WIN_HALF`=15, `MAX_ZEROS`=16, and default sync.

1. Reset check: hold `i_PRESET` for 5 cycles while `rfin` toggles. All outputs stay 0 and `o_LOCK`=0. After release, the first `rfin` pulse gives `o_LOCK`=1 and `o_BIT_VLD` with `o_BIT`=1.
2. Clean frame: 10 random bits, 8 ones, then packet 64'hFDD4_EC5F_595B_51FF with pulses at 90% of slot and no jitter. This gives exactly one `o_PKT_REC` with `o_PKT`=64'hFDD4_EC5F_595B_51FF, and no `o_PKT_REC` during the preamble.
3. Jitter: same frame with each pulse offset by ±12 cycles at random. Same single match and identical `o_PKT`. Offsets of ±20 cycles cause bit errors and no match.
4. Window boundaries: a pulse at t=85 and a pulse at t=115 are both accepted as 1. A pulse at t=84 is ignored. The timeout at t=115 combined with an edge in the same cycle gives bit 1.
5. Lock loss: after lock, send 16 empty slots. Result is 16 zero bits, then `o_LOCK`=0 one cycle after the last zero decision, and no further `o_BIT_VLD` until the next pulse.
6. Reset mid-frame: pulse `i_PRESET` after 40 bits of a valid packet, then send a full packet. Exactly one `o_PKT_REC`, for the second packet only.

Source files
------------

// File: rtl/rf_sync_deframer.sv
// Pulse-position RF bit recovery with slot tracking, followed by a 64-bit
// sync-pattern framer that hands matched packets to the RX register path.
module rf_sync_deframer #(
    parameter int          CLK_PER_BIT = 10000,
    parameter int          WIN_HALF    = 1500,
    parameter int          MAX_ZEROS   = 16,
    parameter logic [63:0] SYNC_MASK   = 64'h7C00_001F_0000_01FF,
    parameter logic [63:0] SYNC_VAL    = 64'h7C00_001F_0000_01FF
) (
    input  logic        i_PCLK,
    input  logic        i_PRESET,
    input  logic        rfin,
    output logic        o_BIT_VLD,
    output logic        o_BIT,
    output logic        o_LOCK,
    output logic [63:0] o_PKT,
    output logic        o_PKT_REC
);
    localparam int TW = $clog2(CLK_PER_BIT + WIN_HALF + 1);
    localparam int ZW = $clog2(MAX_ZEROS + 1);
    localparam logic [TW-1:0] T_LO      = TW'(CLK_PER_BIT - WIN_HALF);
    localparam logic [TW-1:0] T_HI      = TW'(CLK_PER_BIT + WIN_HALF);
    localparam logic [TW-1:0] T_AFTER_0 = TW'(WIN_HALF);
    localparam logic [ZW-1:0] Z_LAST    = ZW'(MAX_ZEROS - 1);
    localparam logic [6:0]    CNT_FULL  = 7'd64;

    typedef enum logic {IDLE, TRACK} state_t;

    state_t          state_q, state_d;
    logic            rf_meta_q, rf_sync_q, rf_prev_q;
    logic [TW-1:0]   t_q, t_d;
    logic [ZW-1:0]   zcnt_q, zcnt_d;
    logic [63:0]     sr_q, sr_d;
    logic [6:0]      cnt_q, cnt_d, cnt_base;
    logic            bit_vld_q, bit_vld_d, bit_q, bit_d;
    logic [63:0]     pkt_q, pkt_d;
    logic            pkt_rec_q, pkt_rec_d;
    logic            rf_edge, in_win, match, decide, dbit, drop;

    assign rf_edge = rf_sync_q & ~rf_prev_q;
    assign in_win  = (t_q >= T_LO) && (t_q <= T_HI);
    // The match looks at sr only in the cycle right after a bit was shifted in.
    assign match   = bit_vld_q && (cnt_q == CNT_FULL) &&
                     ((sr_q & SYNC_MASK) == (SYNC_VAL & SYNC_MASK));

    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        zcnt_d    = zcnt_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        bit_vld_d = 1'b0;
        bit_d     = 1'b0;
        pkt_d     = pkt_q;
        pkt_rec_d = 1'b0;
        decide    = 1'b0;
        dbit      = 1'b0;
        drop      = 1'b0;

        if (match) begin
            pkt_d     = sr_q;
            pkt_rec_d = 1'b1;
            cnt_d     = '0;
        end
        cnt_base = match ? '0 : cnt_q;

        case (state_q)
            IDLE: begin
                if (rf_edge) begin
                    decide  = 1'b1;
                    dbit    = 1'b1;
                    t_d     = '0;
                    zcnt_d  = '0;
                    state_d = TRACK;
                end
            end
            TRACK: begin
                t_d = t_q + TW'(1);
                // An in-window edge outranks a timeout landing in the same cycle.
                if (rf_edge && in_win) begin
                    decide = 1'b1;
                    dbit   = 1'b1;
                    t_d    = '0;
                    zcnt_d = '0;
                end else if (t_q == T_HI) begin
                    decide = 1'b1;
                    t_d    = T_AFTER_0;
                    zcnt_d = zcnt_q + ZW'(1);
                    if (zcnt_q == Z_LAST) begin
                        drop    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (decide) begin
            bit_vld_d = 1'b1;
            bit_d     = dbit;
            sr_d      = {sr_q[62:0], dbit};
            cnt_d     = (cnt_base == CNT_FULL) ? CNT_FULL : cnt_base + 7'd1;
        end
        if (drop) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_PCLK or posedge i_PRESET) begin
        if (i_PRESET) begin
            rf_meta_q <= 1'b0;
            rf_sync_q <= 1'b0;
            rf_prev_q <= 1'b0;
            state_q   <= IDLE;
            t_q       <= '0;
            zcnt_q    <= '0;
            sr_q      <= '0;
            cnt_q     <= '0;
            bit_vld_q <= 1'b0;
            bit_q     <= 1'b0;
            pkt_q     <= '0;
            pkt_rec_q <= 1'b0;
        end else begin
            rf_meta_q <= rfin;
            rf_sync_q <= rf_meta_q;
            rf_prev_q <= rf_sync_q;
            state_q   <= state_d;
            t_q       <= t_d;
            zcnt_q    <= zcnt_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            bit_vld_q <= bit_vld_d;
            bit_q     <= bit_d;
            pkt_q     <= pkt_d;
            pkt_rec_q <= pkt_rec_d;
        end
    end

    assign o_BIT_VLD = bit_vld_q;
    assign o_BIT     = bit_q;
    assign o_LOCK    = (state_q == TRACK);
    assign o_PKT     = pkt_q;
    assign o_PKT_REC = pkt_rec_q;

endmodule

// File: tb/tb_rf_sync_deframer.sv
// Directed bench for rf_sync_deframer: reset, clean/jittered frames, window
// edges, lock loss and mid-frame reset, with hand-computed expectations.
module tb_rf_sync_deframer;
    localparam int SLOT = 101;  // edge-to-edge spacing that lands on t == CLK_PER_BIT
    localparam logic [63:0] PKT   = 64'hFDD4_EC5F_595B_51FF;
    localparam logic [17:0] PRE18 = {10'b1011001010, 8'hFF};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rfin = 1'b0;
    logic        o_BIT_VLD, o_BIT, o_LOCK, o_PKT_REC;
    logic [63:0] o_PKT;

    rf_sync_deframer #(
        .CLK_PER_BIT(100),
        .WIN_HALF   (15),
        .MAX_ZEROS  (16)
    ) dut (
        .i_PCLK   (clk),
        .i_PRESET (rst),
        .rfin     (rfin),
        .o_BIT_VLD(o_BIT_VLD),
        .o_BIT    (o_BIT),
        .o_LOCK   (o_LOCK),
        .o_PKT    (o_PKT),
        .o_PKT_REC(o_PKT_REC)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Passive recorder of decided bits, packet strobes and lock edges.
    logic [127:0] bits_seen = '0;
    logic [127:0] rec_snap  = '0;
    logic [63:0]  rec_pkt   = '0;
    logic         lock_prev = 1'b0;
    int nbits = 0, vld_cyc = 0, rec_total = 0, rec_cyc = 0, rec_vld = 0;
    int rec_nbits = 0, lock_fall_cyc = 0;

    always @(negedge clk) begin
        if (o_BIT_VLD) begin
            bits_seen <= {bits_seen[126:0], o_BIT};
            nbits     <= nbits + 1;
            vld_cyc   <= cyc;
        end
        if (o_PKT_REC) begin
            rec_total <= rec_total + 1;
            rec_pkt   <= o_PKT;
            rec_cyc   <= cyc;
            rec_vld   <= vld_cyc;
            rec_nbits <= nbits;
            rec_snap  <= bits_seen;
        end
        lock_prev <= o_LOCK;
        if (lock_prev && !o_LOCK) lock_fall_cyc <= cyc;
    end

    int n_cmp = 0, n_bad = 0;
    int last_rise = 0;
    logic [31:0]  jpat = 32'hA5C3_96E1;
    logic [63:0]  pkt_v = PKT;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rise_at(input int target);
        while (cyc < target) @(negedge clk);
        rfin = 1'b1;
        last_rise = cyc;
        repeat (3) @(negedge clk);
        rfin = 1'b0;
    endtask

    // bits[n-1] goes first; ones are pulses spaced from the previous pulse by
    // whole slots, shifted by +/-jit chosen from jpat.
    task automatic send_bits(input logic [127:0] bits, input int n, input int jit);
        int gap;
        int j;
        bit first;
        gap = 0;
        first = 1'b1;
        for (int i = n - 1; i >= 0; i--) begin
            gap += SLOT;
            if (bits[i]) begin
                j = jpat[i % 32] ? jit : -jit;
                if (first) rise_at(cyc + 1);
                else rise_at(last_rise + gap + j);
                first = 1'b0;
                gap = 0;
            end
        end
    endtask

    task automatic do_reset(input int n);
        rfin = 1'b0;
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int rb, nb, r0, r1, r2;
        logic [127:0] frame;

        // 1: reset holds everything low while rfin toggles
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rfin = ~rfin;
            @(negedge clk);
            check("reset_outputs", {o_BIT_VLD, o_BIT, o_LOCK, o_PKT_REC, o_PKT}, '0);
        end
        rfin = 1'b0;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_no_bits", nbits, 0);
        check("idle_unlocked", o_LOCK, 0);
        rfin = 1'b1;
        repeat (2) @(negedge clk);
        check("first_bit_latency_early", o_BIT_VLD, 0);
        @(negedge clk);
        rfin = 1'b0;
        check("first_bit_vld_bit_lock", {o_BIT_VLD, o_BIT, o_LOCK}, 3'b111);
        @(negedge clk);
        check("bit_vld_one_cycle", o_BIT_VLD, 0);

        // 2: clean frame, then 5: lock loss on the trailing silence
        do_reset(2);
        rb = rec_total;
        nb = nbits;
        frame = {46'b0, PRE18, PKT};
        send_bits(frame, 82, 0);
        repeat (130) @(negedge clk);
        check("clean_rec_count", rec_total - rb, 1);
        check("clean_pkt", rec_pkt, PKT);
        check("clean_bits_to_match", rec_nbits - nb, 82);
        check("clean_bit_stream", rec_snap & {46'b0, {82{1'b1}}}, frame);
        check("clean_rec_latency", rec_cyc - rec_vld, 1);
        repeat (1650) @(negedge clk);
        check("lockloss_zero_count", nbits - rec_nbits, 16);
        check("lockloss_zero_bits", bits_seen[15:0], 16'h0000);
        check("lockloss_unlocked", o_LOCK, 0);
        check("lockloss_fall_timing", lock_fall_cyc, vld_cyc);
        nb = nbits;
        repeat (400) @(negedge clk);
        check("lockloss_no_more_bits", nbits - nb, 0);
        check("pkt_held", o_PKT, PKT);

        // 3: +/-12 jitter is tracked, +/-20 breaks the frame
        do_reset(2);
        rb = rec_total;
        send_bits(frame, 82, 12);
        repeat (130) @(negedge clk);
        check("jit12_rec_count", rec_total - rb, 1);
        check("jit12_pkt", rec_pkt, PKT);
        check("jit12_o_pkt", o_PKT, PKT);
        do_reset(2);
        rb = rec_total;
        send_bits(frame, 82, 20);
        repeat (130) @(negedge clk);
        check("jit20_no_match", rec_total - rb, 0);

        // 4: window boundaries at t=85, t=115 (edge beats timeout), t=84 ignored
        do_reset(2);
        repeat (3) @(negedge clk);
        nb = nbits;
        rise_at(cyc + 1);
        r0 = last_rise;
        rise_at(r0 + 86);
        r1 = last_rise;
        rise_at(r1 + 116);
        r2 = last_rise;
        rise_at(r2 + 85);
        repeat (2) @(negedge clk);
        check("win_accept_85_115", nbits - nb, 3);
        check("win_bits_111", bits_seen[2:0], 3'b111);
        while (cyc < r2 + 125) @(negedge clk);
        check("win_84_ignored_then_zero", nbits - nb, 4);
        check("win_zero_bit", bits_seen[0], 1'b0);
        check("win_zero_timing", vld_cyc, r2 + 119);
        rise_at(r2 + 2 * SLOT);
        repeat (5) @(negedge clk);
        check("win_stream", {nbits - nb, bits_seen[4:0]}, {32'd5, 5'b11101});

        // 6: reset 40 bits into a packet, then a full packet
        do_reset(2);
        rb = rec_total;
        send_bits({70'b0, PRE18, pkt_v[63:24]}, 58, 0);
        repeat (50) @(negedge clk);
        do_reset(2);
        check("abort_no_rec", rec_total - rb, 0);
        check("abort_cleared", {o_LOCK, o_PKT}, '0);
        nb = nbits;
        send_bits({64'b0, PKT}, 64, 0);
        repeat (130) @(negedge clk);
        check("second_rec_count", rec_total - rb, 1);
        check("second_pkt", rec_pkt, PKT);
        check("second_bits_to_match", rec_nbits - nb, 64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
